// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_det_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count register: clear, increment until all-ones, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != '1)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with registered one-cycle detect pulse.
// Optional match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detect
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    mode_e              ovl_r;
    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic               detect_r;

    logic [MAX_LEN:0]   wide_s;
    logic [MAX_LEN:0]   mask_s;
    logic               fill_ok_s;
    logic               match_s;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (int'(len) > MAX_LEN) begin
            return LEN_W'(MAX_LEN);
        end else begin
            return len;
        end
    endfunction

    // Match evaluation: compare the newest len_r bits (history plus incoming bit) with the pattern.
    always_comb begin
        wide_s    = {hist_r, in};
        mask_s    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_r));
        end
        fill_ok_s = (({1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_r});
        if (in_valid && !cfg_load && (len_r != '0) && fill_ok_s &&
            ((wide_s & mask_s) == ({1'b0, pat_r} & mask_s))) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Active configuration, replaced only by a load strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= MODE_NONOVL;
        end else if (cfg_load) begin
            pat_r <= cfg_pat;
            len_r <= clamp_len(cfg_len);
            ovl_r <= mode_e'(cfg_overlap);
        end else begin
            pat_r <= pat_r;
            len_r <= len_r;
            ovl_r <= ovl_r;
        end
    end

    // History shift, saturating fill count and registered detect pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_r   <= '0;
            fill_r   <= '0;
            detect_r <= 1'b0;
        end else begin
            detect_r <= match_s;
            if (cfg_load) begin
                hist_r <= '0;
                fill_r <= '0;
            end else if (in_valid) begin
                hist_r <= wide_s[MAX_LEN-1:0];
                // Non-overlapping mode restarts the fill so the next match needs fresh bits.
                if (match_s && (ovl_r == MODE_NONOVL)) begin
                    fill_r <= '0;
                end else if (fill_r < len_r) begin
                    fill_r <= fill_r + LEN_W'(1);
                end else begin
                    fill_r <= fill_r;
                end
            end else begin
                hist_r <= hist_r;
                fill_r <= fill_r;
            end
        end
    end

    assign detect = detect_r;

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (match_s),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param against a bit-history reference model.
// Exercises the match counter (including a 2-bit saturating instance) when SEQ_DET_MATCH_CNT_EN is defined.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic               in_valid_s;
    logic               in_s;
    logic               cfg_load_s;
    logic [MAX_LEN-1:0] cfg_pat_s;
    logic [LEN_W-1:0]   cfg_len_s;
    logic               cfg_overlap_s;
    logic               detect_s;
    logic               detect2_s;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt_s;
    logic [1:0]         match_cnt2_s;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: full bit history plus count of bits accepted since the last clear.
    logic [63:0] m_hist;
    logic [31:0] m_pat;
    int          m_len;
    bit          m_ovl;
    int          m_fill;
    int          m_cnt;
    bit          exp_det;

    seq_detect_param #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_s),
        .in          (in_s),
        .cfg_load    (cfg_load_s),
        .cfg_pat     (cfg_pat_s),
        .cfg_len     (cfg_len_s),
        .cfg_overlap (cfg_overlap_s),
        .detect      (detect_s)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt_s)
`endif
    );

    seq_detect_param #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (2)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_s),
        .in          (in_s),
        .cfg_load    (cfg_load_s),
        .cfg_pat     (cfg_pat_s),
        .cfg_len     (cfg_len_s),
        .cfg_overlap (cfg_overlap_s),
        .detect      (detect2_s)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt2_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog against a runaway simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_match(input bit b);
        logic [63:0] mask;
        mask = (64'd1 << m_len) - 64'd1;
        return (m_len > 0) && (m_fill + 1 >= m_len) &&
               ((((m_hist << 1) | {63'd0, b}) & mask) == ({32'd0, m_pat} & mask));
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_hist = 64'd0; m_pat = 32'd0; m_len = 0; m_ovl = 1'b0;
        m_fill = 0; m_cnt = 0; exp_det = 1'b0;
    endtask

    task automatic cycle(input bit v, input bit b);
        bit e;
        @(negedge clk);
        cfg_load_s = 1'b0; in_valid_s = v; in_s = b;
        e = v && model_match(b);
        if (v) begin
            m_hist = (m_hist << 1) | {63'd0, b};
            if (e && !m_ovl) m_fill = 0;
            else m_fill++;
            if (e) m_cnt++;
        end
        @(posedge clk); #1;
        exp_det = e;
    endtask

    task automatic load(input logic [7:0] pat, input int len, input bit ovl, input bit v, input bit b);
        @(negedge clk);
        cfg_load_s = 1'b1; cfg_pat_s = pat; cfg_len_s = LEN_W'(len); cfg_overlap_s = ovl;
        in_valid_s = v; in_s = b;
        m_pat = {24'd0, pat}; m_len = (len > MAX_LEN) ? MAX_LEN : len; m_ovl = ovl;
        m_hist = 64'd0; m_fill = 0; m_cnt = 0;
        @(posedge clk); #1;
        exp_det = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid_s = 1'b0; in_s = 1'b0; cfg_load_s = 1'b0;
        cfg_pat_s = '0; cfg_len_s = '0; cfg_overlap_s = 1'b0;
        model_reset();
        #12;
        checks++;
        if (detect_s !== 1'b0) begin errors++; $display("FAIL reset_detect: got %b want 0", detect_s); end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt_s !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt_s); end
`endif
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (detect_s !== exp_det) begin errors++; $display("FAIL unconfigured[%0d]: got %b want %b", i, detect_s, exp_det); end
        end
    endtask

    task automatic run_stream(input string name, input bit s [8], output int hits);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, s[i]);
            hits += exp_det;
            checks++;
            if (detect_s !== exp_det) begin errors++; $display("FAIL %s[%0d]: got %b want %b", name, i, detect_s, exp_det); end
        end
    endtask

    task automatic test_nonoverlap();
        bit s [8];
        int hits;
        s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        load(8'b0001_1011, 5, 1'b0, 1'b0, 1'b0);
        run_stream("nonovl", s, hits);
        checks++;
        if (hits !== 1) begin errors++; $display("FAIL nonovl_hits: model %0d want 1", hits); end
    endtask

    task automatic test_overlap();
        bit s [8];
        int hits;
        s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        load(8'b0001_1011, 5, 1'b1, 1'b0, 1'b0);
        run_stream("ovl", s, hits);
        checks++;
        if (hits !== 2) begin errors++; $display("FAIL ovl_hits: model %0d want 2", hits); end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt_s !== 16'd2) begin errors++; $display("FAIL ovl_cnt: got %0d want 2", match_cnt_s); end
`endif
    endtask

    task automatic test_gaps();
        bit b [3];
        b = '{1'b1, 1'b0, 1'b1};
        load(8'b0000_0101, 3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, b[k]);
            checks++;
            if (detect_s !== ((k == 2) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL gaps_bit[%0d]: got %b want %b", k, detect_s, (k == 2)); end
            for (int g = 0; g < 3; g++) begin
                cycle(1'b0, 1'($urandom_range(0, 1)));
                checks++;
                if (detect_s !== 1'b0) begin errors++; $display("FAIL gaps_idle[%0d.%0d]: got %b want 0", k, g, detect_s); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit s [5];
        s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        load(8'b0001_1011, 5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, s[i]);
        rst = 1'b0; #2;
        model_reset();
        @(negedge clk); rst = 1'b1;
        cycle(1'b1, s[4]);
        checks++;
        if (detect_s !== 1'b0) begin errors++; $display("FAIL reset_mid: got %b want 0", detect_s); end
        // Second pass: reset while detect is high must clear it without a clock edge.
        load(8'b0001_1011, 5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, s[i]);
        checks++;
        if (detect_s !== 1'b1) begin errors++; $display("FAIL reset_pre_det: got %b want 1", detect_s); end
        rst = 1'b0; #1;
        checks++;
        if (detect_s !== 1'b0) begin errors++; $display("FAIL reset_async_det: got %b want 0", detect_s); end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt_s !== '0) begin errors++; $display("FAIL reset_async_cnt: got %0d want 0", match_cnt_s); end
`endif
        model_reset();
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_len0();
        load(8'($urandom), 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (detect_s !== 1'b0) begin errors++; $display("FAIL len0[%0d]: got %b want 0", i, detect_s); end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] p;
        int hits;
        p = 8'hA5;
        hits = 0;
        load(p, MAX_LEN + 3, 1'b0, 1'b0, 1'b0);
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            cycle(1'b1, p[i]);
            hits += exp_det;
            checks++;
            if (detect_s !== ((i == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL clamp[%0d]: got %b want %b", i, detect_s, (i == 0)); end
        end
        checks++;
        if (hits !== 1) begin errors++; $display("FAIL clamp_model: model %0d want 1", hits); end
    endtask

    task automatic test_load_discard();
        load(8'b0000_0011, 2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        load(8'b0000_0011, 2, 1'b1, 1'b1, 1'b1);
        checks++;
        if (detect_s !== 1'b0) begin errors++; $display("FAIL load_same_cycle: got %b want 0", detect_s); end
        cycle(1'b1, 1'b1);
        checks++;
        if (detect_s !== 1'b0) begin errors++; $display("FAIL load_discard_first: got %b want 0", detect_s); end
        cycle(1'b1, 1'b1);
        checks++;
        if (detect_s !== 1'b1) begin errors++; $display("FAIL load_discard_second: got %b want 1", detect_s); end
    endtask

    task automatic test_len1_sat();
        load(8'b0000_0001, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1);
            checks++;
            if (detect_s !== 1'b1 || detect2_s !== 1'b1) begin errors++; $display("FAIL len1[%0d]: got %b/%b want 1", i, detect_s, detect2_s); end
`ifdef SEQ_DET_MATCH_CNT_EN
            checks++;
            if (match_cnt2_s !== 2'(sat(m_cnt, 2))) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, match_cnt2_s, sat(m_cnt, 2)); end
`endif
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (detect_s !== 1'b0) begin errors++; $display("FAIL len1_zero: got %b want 0", detect_s); end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt2_s !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", match_cnt2_s); end
`endif
    endtask

    task automatic test_random();
        int r;
        for (int round = 0; round < 6; round++) begin
            load(8'($urandom), (round % 2 == 0) ? $urandom_range(1, 4) : $urandom_range(0, MAX_LEN + 3),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            for (int i = 0; i < 120; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3) load(8'($urandom), $urandom_range(0, MAX_LEN + 3), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else cycle(r < 73, 1'($urandom_range(0, 1)));
                checks++;
                if (detect_s !== exp_det || detect2_s !== exp_det) begin
                    errors++; $display("FAIL random[%0d.%0d]: got %b/%b want %b", round, i, detect_s, detect2_s, exp_det);
                end
`ifdef SEQ_DET_MATCH_CNT_EN
                checks++;
                if (match_cnt_s !== CNT_W'(sat(m_cnt, CNT_W)) || match_cnt2_s !== 2'(sat(m_cnt, 2))) begin
                    errors++; $display("FAIL random_cnt[%0d.%0d]: got %0d/%0d want %0d", round, i, match_cnt_s, match_cnt2_s, m_cnt);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_gaps();
        test_reset_mid();
        test_len0();
        test_clamp();
        test_load_discard();
        test_len1_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the longest detectable pattern in bits (legal range 2..32).
REQ-002 Parameter LEN_W, default $clog2(MAX_LEN+1), SHALL set the width of the length fields.
REQ-003 Parameter CNT_W, default 16, SHALL set the match counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL qualify in; bits are consumed only when high.
REQ-007 in  input  1  SHALL be the serial data bit.
REQ-008 cfg_load  input  1  SHALL be a one-cycle strobe that latches cfg_pat, cfg_len and cfg_overlap.
REQ-009 cfg_pat  input  MAX_LEN  SHALL carry the pattern; bit [len-1] is received first and bit [0] last.
REQ-010 cfg_len  input  LEN_W  SHALL carry the pattern length in bits.
REQ-011 cfg_overlap  input  1  SHALL select the mode: 1 = overlapping, 0 = non-overlapping.
REQ-012 detect  output  1  SHALL be a registered one-cycle pulse on a match.
REQ-013 match_cnt  output  CNT_W  SHALL report the number of matches (present only per REQ-030).

Function
REQ-014 The block SHALL hold active registers pat_r, len_r and ovl_r, loaded only on cfg_load.
REQ-015 The block SHALL shift each valid bit into a MAX_LEN-bit history register, newest bit at [0].
REQ-016 The block SHALL keep a fill counter of valid bits accepted since the last clear, saturating at len_r.
REQ-017 A match SHALL occur on a valid cycle when fill+1 >= len_r and {history[len_r-2:0], in} equals pat_r[len_r-1:0].
REQ-018 On a match, detect SHALL be 1 in the cycle after the edge that sampled the final bit, giving one-cycle latency (registered Mealy).
REQ-019 detect SHALL be 0 on every cycle not following a match, including in_valid-low cycles.
REQ-020 In overlapping mode, history and fill SHALL be kept after a match.
REQ-021 In non-overlapping mode, fill SHALL be cleared to 0 after a match, so the next match needs len_r fresh bits.
REQ-022 cfg_len = 0 SHALL disable detection, and detect SHALL stay 0.
REQ-023 cfg_len > MAX_LEN SHALL be clamped to MAX_LEN at load.
REQ-024 cfg_len = 1 SHALL match every valid bit equal to pat_r[0].
REQ-025 cfg_load SHALL clear fill and history; a bit presented in the same cycle SHALL be discarded, and no match SHALL be evaluated in that cycle.
REQ-026 When in_valid is low, history, fill and the counter SHALL hold.

Reset
REQ-027 Asserting rst low SHALL immediately force detect=0, history=0, fill=0 and match_cnt=0.
REQ-028 Reset SHALL force pat_r=0, len_r=0 and ovl_r=0, leaving detection disabled until the first cfg_load.
REQ-029 Reset mid-sequence SHALL discard partial progress; release SHALL be synchronised by the integrator, and the block SHALL add no synchroniser.

Configuration
REQ-030 With SEQ_DET_MATCH_CNT_EN defined, match_cnt SHALL increment on each match and saturate at all-ones.
REQ-031 With SEQ_DET_MATCH_CNT_EN defined, match_cnt SHALL clear on cfg_load.
REQ-032 Without SEQ_DET_MATCH_CNT_EN, the match_cnt port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package seq_det_pkg SHALL hold the mode constants MODE_NONOVL=0 and MODE_OVL=1.
REQ-034 seq_det_pkg SHALL also hold the default MAX_LEN and CNT_W values.
REQ-035 A sub-module seq_det_sat_cnt (parameterised width, inc/clr/saturate) SHALL implement the counter.
REQ-036 seq_det_sat_cnt SHALL be instantiated only under SEQ_DET_MATCH_CNT_EN.
REQ-037 All other logic (history, fill, compare) SHALL reside in seq_detect_param.

Verification
REQ-038 Load pat=11011, len=5, ovl=0; stream 1,1,0,1,1,0,1,1 -> exactly one detect, one cycle after bit 5.
REQ-039 Same stream with ovl=1 -> detect after bit 5 and after bit 8; match_cnt=2 when the counter is enabled.
REQ-040 Pattern 101, ovl=1, stream 1,0,1 with in_valid low for 3 cycles between bits -> one detect after the final valid bit.
REQ-041 Pattern 11011 with rst asserted after bit 4 of 1,1,0,1,1 -> no detect, and outputs 0 asynchronously.
REQ-042 cfg_load with len=0, then any stream -> detect never asserted.
REQ-043 cfg_load with len=MAX_LEN+3 and a MAX_LEN-bit pattern -> clamped; detect fires after MAX_LEN matching bits.
REQ-044 Counter saturation (CNT_W=2, len=1, pat=1, ovl=1, six 1s) -> match_cnt holds at 3.
